// File: rtl/ftb_pkg.sv
// Shared types and constants for the find-the-bomb game controller.
// State, direction and screen codes are fixed encodings seen by the OLED mux and debug logic.
package ftb_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_PLAY  = 3'd2,
        S_WIN   = 3'd3,
        S_LOSE  = 3'd4
    } ftb_state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } ftb_dir_t;

    typedef enum logic [1:0] {
        SCR_MAZE  = 2'd0,
        SCR_START = 2'd1,
        SCR_WIN   = 2'd2,
        SCR_LOSE  = 2'd3
    } ftb_screen_t;

    localparam int         GRID      = 5;
    localparam logic [4:0] GOAL_CELL = 5'd24;

    function automatic ftb_screen_t screen_of(input ftb_state_t s);
        case (s)
            S_START: return SCR_START;
            S_WIN:   return SCR_WIN;
            S_LOSE:  return SCR_LOSE;
            default: return SCR_MAZE;
        endcase
    endfunction

endpackage

// File: rtl/ftb_game_ctrl_if.sv
// Signal bundle between the menu/button/audio side (master) and the game controller (slave).
// move_valid is a one-cycle request with no ready: the controller consumes it in the same cycle, acting only in play.
interface ftb_game_ctrl_if;

    logic       enable;
    logic       start;
    logic       move_valid;
    logic [1:0] move_dir;
    logic [2:0] game_state;
    logic [1:0] screen_sel;
    logic [4:0] position;
    logic [4:0] bomb;
    logic [4:0] moves_left;
    logic       bump;

    modport master (
        output enable, start, move_valid, move_dir,
        input  game_state, screen_sel, position, bomb, moves_left, bump
    );

    modport slave (
        input  enable, start, move_valid, move_dir,
        output game_state, screen_sel, position, bomb, moves_left, bump
    );

endinterface

// File: rtl/ftb_lfsr8.sv
// Free-running 8-bit maximal-length LFSR (x^8+x^6+x^5+x^4+1), seeded 8'hA5 on reset.
module ftb_lfsr8 (
    input  logic       clock,
    input  logic       rst_n,
    output logic [7:0] out
);

    logic [7:0] r_lfsr;
    logic       w_fb;

    assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) r_lfsr <= 8'hA5;
        else        r_lfsr <= {r_lfsr[6:0], w_fb};
    end

    assign out = r_lfsr;

endmodule

// File: rtl/ftb_game_ctrl.sv
// Find-the-bomb game sequencer: start screen, play on a 5x5 maze, win/lose screens.
// Owns player position, bomb placement and the move budget; all outputs are registered.
module ftb_game_ctrl
    import ftb_pkg::*;
#(
    parameter int START_CYCLES = 200_000_000,
    parameter int END_CYCLES   = 50_000_000,
    parameter int MAX_MOVES    = 16
) (
    input  logic           clock,
    input  logic           rst_n,
    ftb_game_ctrl_if.slave game
);

    localparam logic [27:0] START_LAST = 28'(START_CYCLES - 1);
    localparam logic [27:0] END_LAST   = 28'(END_CYCLES - 1);
    localparam logic [4:0]  MAX_MV     = 5'(MAX_MOVES);

    ftb_state_t  r_state,      w_state_nxt;
    logic [27:0] r_timer,      w_timer_nxt;
    logic [4:0]  r_position,   w_position_nxt;
    logic [4:0]  r_bomb,       w_bomb_nxt;
    logic [4:0]  r_moves_left, w_moves_nxt;
    logic        r_bump,       w_bump_nxt;
    ftb_screen_t r_screen_sel;
    logic        r_start_q;

    logic [7:0]  w_lfsr;
    logic        w_start_rise;
    logic [2:0]  w_row;
    logic [2:0]  w_col;
    logic [4:0]  w_target;
    logic        w_legal;
    logic [4:0]  w_bomb_new;

    ftb_lfsr8 u_lfsr (
        .clock (clock),
        .rst_n (rst_n),
        .out   (w_lfsr)
    );

    assign w_start_rise = game.start & ~r_start_q;
    assign w_row        = 3'(r_position / 5'(GRID));
    assign w_col        = 3'(r_position % 5'(GRID));
    assign w_bomb_new   = 5'((w_lfsr % 8'd23) + 8'd1);

    always_comb begin
        w_target = r_position;
        w_legal  = 1'b0;
        case (ftb_dir_t'(game.move_dir))
            DIR_UP: begin
                w_legal  = (w_row != 3'd0);
                w_target = r_position - 5'(GRID);
            end
            DIR_DOWN: begin
                w_legal  = (w_row != 3'(GRID - 1));
                w_target = r_position + 5'(GRID);
            end
            DIR_LEFT: begin
                w_legal  = (w_col != 3'd0);
                w_target = r_position - 5'd1;
            end
            default: begin
                w_legal  = (w_col != 3'(GRID - 1));
                w_target = r_position + 5'd1;
            end
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = r_timer + 28'd1;
        w_position_nxt = r_position;
        w_bomb_nxt     = r_bomb;
        w_moves_nxt    = r_moves_left;
        w_bump_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_timer_nxt = '0;
                if (game.enable) w_state_nxt = S_START;
            end
            S_START: begin
                if (r_timer == START_LAST || w_start_rise) begin
                    w_state_nxt    = S_PLAY;
                    w_position_nxt = '0;
                    w_moves_nxt    = MAX_MV;
                    w_bomb_nxt     = w_bomb_new;
                end
            end
            S_PLAY: begin
                if (game.move_valid) begin
                    if (w_legal) begin
                        w_position_nxt = w_target;
                        w_moves_nxt    = r_moves_left - 5'd1;
                        // Bomb beats goal, goal beats an exhausted budget.
                        if (w_target == r_bomb)          w_state_nxt = S_LOSE;
                        else if (w_target == GOAL_CELL)  w_state_nxt = S_WIN;
                        else if (r_moves_left == 5'd1)   w_state_nxt = S_LOSE;
                    end else begin
                        w_bump_nxt = 1'b1;
                    end
                end
            end
            S_WIN, S_LOSE: begin
                if (r_timer == END_LAST) w_state_nxt = S_START;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (!game.enable) begin
            w_state_nxt    = S_IDLE;
            w_position_nxt = '0;
            w_bomb_nxt     = '0;
            w_moves_nxt    = '0;
            w_bump_nxt     = 1'b0;
        end
        if (w_state_nxt != r_state) w_timer_nxt = '0;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_position   <= '0;
            r_bomb       <= '0;
            r_moves_left <= '0;
            r_bump       <= 1'b0;
            r_screen_sel <= SCR_MAZE;
            // A button already held at reset release must not count as a press.
            r_start_q    <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_position   <= w_position_nxt;
            r_bomb       <= w_bomb_nxt;
            r_moves_left <= w_moves_nxt;
            r_bump       <= w_bump_nxt;
            r_screen_sel <= screen_of(w_state_nxt);
            r_start_q    <= game.start;
        end
    end

    assign game.game_state = r_state;
    assign game.screen_sel = r_screen_sel;
    assign game.position   = r_position;
    assign game.bomb       = r_bomb;
    assign game.moves_left = r_moves_left;
    assign game.bump       = r_bump;

endmodule
